// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture / PMOD packer slice.
package cam_pkg;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_RAW8   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] pix;
    } fifo_entry_t;

    // The reserved encoding behaves as RAW8.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_RGB565;
            2'd1:    return MODE_RGB444;
            default: return MODE_RAW8;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] pack_pixel(input mode_e m, input logic [7:0] hi,
                                                     input logic [7:0] lo);
        case (m)
            MODE_RGB565: return {hi, lo};
            MODE_RGB444: return {4'h0, hi[3:0], lo};
            default:     return {8'h00, lo};
        endcase
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Synchronous pixel FIFO; a push is accepted when full if a pop happens in the same cycle.
module cam_pix_fifo
    import cam_pkg::*;
#(
    parameter int WIDTH = PIX_W + 1,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cam_capture_packer.sv
// Camera bus oversampler, frame/pixel assembler and MSB-first PMOD serialiser.
//   state   | meaning
//   IDLE    | capture off; mode latched when enable_i rises
//   WAIT_VS | armed, waiting for the vsync falling edge
//   ACTIVE  | capturing bytes on pclk rising edges while href is high
module cam_capture_packer
    import cam_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OUT_W       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int CHUNK_DIV   = 2,
    parameter int FCNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    input  logic              clr_i,
    input  logic              pclk_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        data_i,
    output logic              pmod_write_en_o,
    output logic              pmod_sof_o,
    output logic [OUT_W-1:0]  pmod_data_o,
    output logic [FCNT_W-1:0] frame_cnt_o,
    output logic              overflow_o,
    output logic              line_err_o,
    output logic              busy_o
);

    localparam int NCHUNK = PIX_W / OUT_W;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int TW     = (CHUNK_DIV > 1) ? $clog2(CHUNK_DIV) : 1;

    // All camera pins share one chain so pclk, vsync, href and data stay aligned.
    logic [10:0] sync_q [SYNC_STAGES];
    logic        pclk_s, vsync_s, href_s;
    logic [7:0]  data_s;
    logic        pclk_d, vsync_d, href_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            sync_q[0] <= {pclk_i, vsync_i, href_i, data_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            pclk_d  <= pclk_s;
            vsync_d <= vsync_s;
            href_d  <= href_s;
        end
    end

    assign pclk_s  = sync_q[SYNC_STAGES-1][10];
    assign vsync_s = sync_q[SYNC_STAGES-1][9];
    assign href_s  = sync_q[SYNC_STAGES-1][8];
    assign data_s  = sync_q[SYNC_STAGES-1][7:0];

    logic sample_evt, vs_fall, vs_rise, href_fall;

    assign sample_evt = pclk_s & ~pclk_d;
    assign vs_fall    = vsync_d & ~vsync_s;
    assign vs_rise    = ~vsync_d & vsync_s;
    assign href_fall  = href_d & ~href_s;

    state_e state_q, state_d;
    mode_e  mode_q;
    logic   latch_mode, arm_sof, frame_done;

    always_comb begin
        state_d    = state_q;
        latch_mode = 1'b0;
        arm_sof    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = WAIT_VS;
                    latch_mode = 1'b1;
                end
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    arm_sof = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    frame_done = 1'b1;
                    if (enable_i) begin
                        state_d    = WAIT_VS;
                        latch_mode = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel assembly and FIFO write side.
    logic        capture, two_byte, pix_done, drop;
    logic        phase_q, sof_armed_q;
    logic [7:0]  b0_q;
    logic [PIX_W-1:0] pix_word;
    fifo_entry_t fifo_wdata, fifo_rdata;
    logic        fifo_full, fifo_empty, pop;

    assign capture    = (state_q == ACTIVE) && sample_evt && href_s;
    assign two_byte   = (mode_q != MODE_RAW8);
    assign pix_done   = capture && (!two_byte || phase_q);
    assign pix_word   = pack_pixel(mode_q, b0_q, data_s);
    assign fifo_wdata = {sof_armed_q, pix_word};
    assign drop       = pix_done && fifo_full && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mode_q      <= MODE_RGB565;
            phase_q     <= 1'b0;
            b0_q        <= '0;
            sof_armed_q <= 1'b0;
            frame_cnt_o <= '0;
            overflow_o  <= 1'b0;
            line_err_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_mode) mode_q <= decode_mode(mode_i);
            if (arm_sof || href_fall) begin
                phase_q <= 1'b0;
            end else if (capture && two_byte) begin
                phase_q <= ~phase_q;
            end
            if (capture && two_byte && !phase_q) b0_q <= data_s;
            // A dropped sof pixel leaves the flag armed for the next push.
            if (arm_sof) begin
                sof_armed_q <= 1'b1;
            end else if (pix_done && !drop) begin
                sof_armed_q <= 1'b0;
            end
            if (frame_done) frame_cnt_o <= frame_cnt_o + 1'b1;
            overflow_o <= drop | (overflow_o & ~clr_i);
            line_err_o <= (href_fall & phase_q) | (line_err_o & ~clr_i);
        end
    end

    cam_pix_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pix_done),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Serialiser: timer is a down-counter, a chunk goes out when it reaches zero.
    logic [CW-1:0]    chunks_q;
    logic [TW-1:0]    timer_q;
    logic [PIX_W-1:0] sr_q;
    logic             first_q;
    logic             emit, last_emit;

    assign emit      = (chunks_q != '0) && (timer_q == '0);
    assign last_emit = emit && (chunks_q == CW'(1));
    // Popping alongside the last chunk keeps back-to-back pixels at CHUNK_DIV spacing.
    assign pop       = !fifo_empty && (((chunks_q == '0) && (timer_q == '0)) || last_emit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chunks_q        <= '0;
            timer_q         <= '0;
            sr_q            <= '0;
            first_q         <= 1'b0;
            pmod_write_en_o <= 1'b0;
            pmod_sof_o      <= 1'b0;
            pmod_data_o     <= '0;
        end else begin
            pmod_write_en_o <= emit;
            pmod_sof_o      <= emit & first_q;
            if (emit) pmod_data_o <= sr_q[PIX_W-1 -: OUT_W];
            if (pop) begin
                sr_q     <= fifo_rdata.pix;
                first_q  <= fifo_rdata.sof;
                chunks_q <= CW'(NCHUNK);
                timer_q  <= last_emit ? TW'(CHUNK_DIV - 1) : '0;
            end else if (emit) begin
                sr_q     <= sr_q << OUT_W;
                first_q  <= 1'b0;
                chunks_q <= chunks_q - 1'b1;
                timer_q  <= TW'(CHUNK_DIV - 1);
            end else if (timer_q != '0) begin
                timer_q <= timer_q - 1'b1;
            end
        end
    end

    assign busy_o = (state_q != IDLE) || !fifo_empty || (chunks_q != '0);

endmodule

// File: doc/cam_capture_packer.md
Name: cam_capture_packer

Overview:
Parametrised successor to the camera-to-PMOD data path.
- Oversamples the OV-style camera bus (pclk, vsync, href, 8-bit data) in the system clock domain.
- Frames the capture on vsync/href and assembles pixels in a run-time selectable format (RGB565, RGB444, RAW8).
- Buffers whole pixels in a FIFO, then serialises each pixel MSB-first onto a PMOD bus of parametrised width at a programmable chunk rate, with start-of-frame marking and error reporting.
- Sits between the camera pins and the PMOD output inside video_top.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on every camera input; minimum 2.
- OUT_W, 4: PMOD data width in bits; must be 1, 2, 4, 8 or 16.
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, at least 4.
- CHUNK_DIV, 2: clocks per emitted chunk; at least 1.
- FCNT_W, 16: frame counter width.

Ports:
- clk_i, in, 1: system clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- enable_i, in, 1: capture enable; sampled only at frame boundaries.
- mode_i, in, 2: pixel format. 0 = RGB565, 1 = RGB444, 2 = RAW8, 3 = reserved (treated as RAW8).
- clr_i, in, 1: clears the sticky flags.
- pclk_i, in, 1: camera pixel clock, asynchronous to clk_i.
- vsync_i, in, 1: camera vsync; high during vertical blanking.
- href_i, in, 1: camera line-valid.
- data_i, in, 8: camera data.
- pmod_write_en_o, out, 1: one-cycle strobe per chunk.
- pmod_sof_o, out, 1: high with the first chunk of a frame.
- pmod_data_o, out, OUT_W: current chunk.
- frame_cnt_o, out, FCNT_W: completed-frame count; wraps.
- overflow_o, out, 1: sticky; a pixel was dropped because the FIFO was full.
- line_err_o, out, 1: sticky; a line ended on an odd byte in a 2-byte mode.
- busy_o, out, 1: FSM not IDLE, FIFO not empty, or serialiser active.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; all counters 0.
- Input sync
  - pclk, vsync, href and data pass through SYNC_STAGES flops each, so they stay mutually aligned.
  - Sample event = synchronised pclk rising edge (registered previous value 0, current value 1).
- Frame FSM (state changes only on clk_i)
  - IDLE: when enable_i=1, go to WAIT_VS. mode_i is latched here and held for the whole frame.
  - WAIT_VS: on a synchronised vsync falling edge, go to ACTIVE and arm the sof flag.
  - ACTIVE: each sample event with href=1 captures one byte. On a synchronised vsync rising edge: frame_cnt_o increments; next state is WAIT_VS if enable_i=1, otherwise IDLE.
  - enable_i deassertion during ACTIVE takes effect only at the end of the frame.
- Byte assembly
  - In 2-byte modes the first byte of a pair is the high byte; a pixel completes on the second byte.
  - The byte phase resets on href falling edge. A pending odd byte is discarded and line_err_o is set.
- Pixel word (16 bits)
  - RGB565: {b0, b1}.
  - RGB444: {4'h0, b0[3:0], b1}.
  - RAW8: {8'h0, b0}.
- FIFO
  - Entry = {sof, pixel16}. sof is 1 on the first pixel pushed after arming, then cleared.
  - Push on pixel complete. If the FIFO is full: drop the pixel and set overflow_o.
  - A dropped sof pixel transfers sof to the next pushed pixel.
  - The FIFO is never flushed between frames.
- Serialiser
  - When idle and the FIFO is not empty: pop, then emit 16/OUT_W chunks MSB-first, one every CHUNK_DIV clocks; the first chunk is emitted on the cycle after the pop.
  - pmod_write_en_o is high for exactly 1 cycle per chunk.
  - pmod_data_o holds its value until the next chunk.
  - pmod_sof_o equals the entry's sof on the first chunk only; otherwise 0.
  - Back-to-back pixels leave no gap beyond CHUNK_DIV spacing.
- Latency: with the FIFO empty and the serialiser idle, the first chunk's write_en occurs exactly SYNC_STAGES+3 clk_i cycles after the pclk pin edge that completes the pixel.
- Simultaneous events
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - clr_i and a new error event in the same cycle: the flag stays set.
- Asynchronous reset mid-frame: immediate return to the reset state; capture restarts at the next vsync fall once enable_i=1.

Decomposition:
- Package cam_pkg: mode enum (MODE_RGB565, MODE_RGB444, MODE_RAW8), FSM state enum (IDLE, WAIT_VS, ACTIVE), PIX_W=16 constant, FIFO entry struct {sof, pix}.
- Sub-module cam_pix_fifo: synchronous FIFO, parametrised depth and width; full/empty flags; simultaneous push and pop allowed when full.

Test Plan:
- RGB565, OUT_W=4, CHUNK_DIV=2; one line of bytes 0xA5,0x3C,0x12,0x34 → chunks A,5,3,C,1,2,3,4, each 2 clocks apart; sof only on the A chunk.
- RGB444, bytes 0xF7,0x9E → pixel 0x079E; chunks 0,7,9,E.
- RAW8, bytes 0x81,0x42 → pixels 0x0081, 0x0042; chunks 0,0,8,1,0,0,4,2.
- Line of 3 bytes in RGB565 → 1 pixel emitted; line_err_o=1; clr_i pulse → line_err_o=0.
- FIFO_DEPTH=4, CHUNK_DIV=64, 10 pixels at full pclk rate → overflow_o=1; every emitted pixel matches a sent pixel, in order.
- Three vsync cycles with enable_i dropped mid-second-frame → frame_cnt_o ends at 2, FSM in IDLE, busy_o falls after the FIFO drains.
